// File: rtl/ama_riscv_pkg.sv
// Shared fetch-stage types and constants, plus the DFF_RST register macro.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
`ifndef AMA_RISCV_DFF_RST
`define AMA_RISCV_DFF_RST
`define DFF_RST(q, d, rst, clk, rv) \
  always_ff @(posedge clk) begin \
    if (rst) q <= rv; \
    else q <= d; \
  end
`endif

package ama_riscv_pkg;

  localparam logic [31:0] RV_NOP               = 32'h0000_0013;
  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/ama_riscv_fifo.sv
// Generic synchronous FIFO with flush; DEPTH need not be a power of two.
// Latency: a pushed word is visible on dout the cycle after the push.
// Backpressure: push is ignored when full unless a pop happens the same cycle; flush wins over push/pop.
`ifndef AMA_RISCV_DFF_RST
`define AMA_RISCV_DFF_RST
`define DFF_RST(q, d, rst, clk, rv) \
  always_ff @(posedge clk) begin \
    if (rst) q <= rv; \
    else q <= d; \
  end
`endif

module ama_riscv_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [DEPTH-1:0][WIDTH-1:0] mem, mem_d;
  logic [AW-1:0] wr_ptr, wr_ptr_d, rd_ptr, rd_ptr_d;
  logic [CW-1:0] cnt_d;
  logic do_push, do_pop;

  // Pointers wrap explicitly so non-power-of-two depths work
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Next-state: flush empties the FIFO, otherwise apply push and pop together
  always_comb begin
    mem_d    = mem;
    wr_ptr_d = wr_ptr;
    rd_ptr_d = rd_ptr;
    cnt_d    = count;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr] = din;
        wr_ptr_d      = ptr_inc(wr_ptr);
      end
      if (do_pop) rd_ptr_d = ptr_inc(rd_ptr);
      cnt_d = count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage array
  `DFF_RST(mem, mem_d, rst, clk, '0)
  // Write pointer
  `DFF_RST(wr_ptr, wr_ptr_d, rst, clk, '0)
  // Read pointer
  `DFF_RST(rd_ptr, rd_ptr_d, rst, clk, '0)
  // Occupancy
  `DFF_RST(count, cnt_d, rst, clk, '0)

  assign dout  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/ama_riscv_fetch.sv
// IF stage: owns the PC, requests IMEM, buffers {pc,inst} for the decoder, drops stale responses on redirect.
// Latency: request fire to dec_valid = IMEM latency + 1 clk; 1 inst/clk with 1-clk IMEM and dec_ready high.
// Backpressure: queue space is reserved at request time, so imem_rsp_ready is tied high; dec_ready low stalls requests.
`ifndef AMA_RISCV_DFF_RST
`define AMA_RISCV_DFF_RST
`define DFF_RST(q, d, rst, clk, rv) \
  always_ff @(posedge clk) begin \
    if (rst) q <= rv; \
    else q <= d; \
  end
`endif

module ama_riscv_fetch
  import ama_riscv_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
  parameter int          MAX_OUTST    = 2,
  parameter int          QDEPTH       = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  output logic        imem_rsp_ready,
  input  logic [31:0] imem_rsp_data,
  input  logic        dec_ready,
  output logic        dec_valid,
  output logic [31:0] dec_inst,
  output logic [31:0] dec_pc
);

  localparam int OW  = $clog2(MAX_OUTST + 1);
  localparam int QCW = $clog2(QDEPTH + 1);

  logic              rst_q;
  logic [31:0]       pc, pc_d;
  logic [OW-1:0]     outst, outst_d, drop, drop_d;
  logic              fire, rsp_in, head_leaving;
  logic              q_push, q_full, q_empty;
  logic [QCW-1:0]    q_count;
  fetch_entry_t      q_din, q_head;
  logic [31:0]       tag_head;
  logic              tag_full, tag_empty;
  logic [OW-1:0]     tag_count;
  logic [31:0]       slots_used;
  logic              unused_sigs;

  // A head leaving this cycle frees its slot, which keeps 1 inst/clk with a 2-entry queue
  assign head_leaving = !q_empty && dec_ready;
  assign slots_used   = 32'(outst) + 32'(q_count) - 32'(head_leaving);

  assign imem_req_valid = !rst_q && !redirect && (slots_used < 32'(QDEPTH))
                          && (32'(outst) < 32'(MAX_OUTST));
  assign imem_req_addr  = pc;
  assign imem_rsp_ready = 1'b1;

  assign fire   = imem_req_valid && imem_req_ready;
  // Responses with nothing in flight (stragglers from before a reset) are ignored
  assign rsp_in = imem_rsp_valid && (outst != '0);
  assign q_push = rsp_in && (drop == '0);
  assign q_din  = '{pc: tag_head, inst: imem_rsp_data};

  // PC tags of in-flight requests; popped by every response, dropped or not
  ama_riscv_fifo #(.WIDTH(32), .DEPTH(MAX_OUTST)) u_tag_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fire),
    .din   (pc),
    .pop   (rsp_in),
    .flush (1'b0),
    .dout  (tag_head),
    .full  (tag_full),
    .empty (tag_empty),
    .count (tag_count)
  );

  // Instruction queue towards DEC; redirect flushes it and overrides push/pop
  ama_riscv_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(QDEPTH)) u_inst_q (
    .clk   (clk),
    .rst   (rst),
    .push  (q_push),
    .din   (q_din),
    .pop   (dec_ready),
    .flush (redirect),
    .dout  (q_head),
    .full  (q_full),
    .empty (q_empty),
    .count (q_count)
  );

  // Next-state for PC and counters; redirect marks everything still in flight as stale
  always_comb begin
    pc_d    = pc;
    outst_d = outst + OW'(fire) - OW'(rsp_in);
    drop_d  = drop;
    if (redirect) begin
      pc_d   = {redirect_pc[31:2], 2'b00};
      drop_d = outst - OW'(rsp_in);
    end else begin
      if (fire) pc_d = pc + 32'd4;
      if (rsp_in && (drop != '0)) drop_d = drop - OW'(1);
    end
  end

  // Reset delayed one clock so the first request follows reset release by a cycle
  `DFF_RST(rst_q, 1'b0, rst, clk, 1'b1)
  // Fetch PC
  `DFF_RST(pc, pc_d, rst, clk, RESET_VECTOR)
  // Requests in flight
  `DFF_RST(outst, outst_d, rst, clk, '0)
  // Stale responses still to discard
  `DFF_RST(drop, drop_d, rst, clk, '0)

  // Decoder-facing outputs: NOP when nothing is valid
  always_comb begin
    dec_valid = !q_empty;
    dec_inst  = dec_valid ? q_head.inst : RV_NOP;
    dec_pc    = dec_valid ? q_head.pc : pc;
  end

  assign unused_sigs = ^{redirect_pc[1:0], tag_full, tag_empty, tag_count};

  // In-flight count stays within its bound
  a_outst_max: assert property (@(posedge clk) disable iff (rst)
    32'(outst) <= 32'(MAX_OUTST));
  // Stale count never exceeds what is in flight
  a_drop_le_outst: assert property (@(posedge clk) disable iff (rst)
    drop <= outst);
  // Queue is never pushed while full without a same-cycle pop
  a_q_no_ovf: assert property (@(posedge clk) disable iff (rst)
    !(q_push && q_full && !dec_ready && !redirect));
  // IMEM only answers requests that were issued
  a_rsp_has_req: assert property (@(posedge clk) disable iff (rst)
    imem_rsp_valid |-> (outst != '0));

endmodule

// File: tb/tb_ama_riscv_fetch.sv
// Directed bench for ama_riscv_fetch with an in-order IMEM model of programmable latency.
// Latency: IMEM answers a request fired at edge n during the cycle after edge n+lat-1.
// Backpressure: IMEM always ready; DEC readiness driven per scenario.
module tb_ama_riscv_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic        imem_rsp_ready;
  logic [31:0] imem_rsp_data = 32'h0;
  logic        dec_ready = 1'b1;
  logic        dec_valid;
  logic [31:0] dec_inst;
  logic [31:0] dec_pc;

  int n_vec = 0;
  int n_bad = 0;
  int lat = 1;
  int cyc = 0;
  logic [31:0] pend_a[$];
  int          pend_t[$];

  ama_riscv_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_ready (imem_rsp_ready),
    .imem_rsp_data  (imem_rsp_data),
    .dec_ready      (dec_ready),
    .dec_valid      (dec_valid),
    .dec_inst       (dec_inst),
    .dec_pc         (dec_pc)
  );

  always #5 clk = ~clk;

  // One clock: sample handshakes before the edge, then advance the IMEM model after it
  task automatic step();
    logic f, r, rs;
    logic [31:0] a;
    #1;
    f  = imem_req_valid && imem_req_ready;
    r  = imem_rsp_valid;
    rs = rst;
    a  = imem_req_addr;
    @(posedge clk);
    #1;
    cyc++;
    if (rs) begin
      pend_a.delete();
      pend_t.delete();
    end else begin
      if (r && pend_a.size() > 0) begin
        void'(pend_a.pop_front());
        void'(pend_t.pop_front());
      end
      if (f === 1'b1) begin
        pend_a.push_back(a);
        pend_t.push_back(cyc + lat - 1);
      end
    end
    if (pend_a.size() > 0 && pend_t[0] <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'hA000_0000 | pend_a[0];
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    redirect = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    n_vec++; if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL rst_req_valid: got %b want 0", imem_req_valid); end
    n_vec++; if (dec_valid !== 1'b0) begin n_bad++; $display("FAIL rst_dec_valid: got %b want 0", dec_valid); end
    n_vec++; if (dec_inst !== 32'h0000_0013) begin n_bad++; $display("FAIL rst_dec_inst: got %h want 00000013", dec_inst); end
    n_vec++; if (dec_pc !== 32'h0) begin n_bad++; $display("FAIL rst_dec_pc: got %h want 00000000", dec_pc); end
    rst = 1'b0;
    #1;
    n_vec++; if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL rst_release_hold: got %b want 0", imem_req_valid); end
    step();
    n_vec++; if (imem_req_valid !== 1'b1) begin n_bad++; $display("FAIL rst_first_req: got %b want 1", imem_req_valid); end
    n_vec++; if (imem_req_addr !== 32'h0) begin n_bad++; $display("FAIL rst_first_addr: got %h want 00000000", imem_req_addr); end
  endtask

  task automatic test_stream();
    lat = 1;
    dec_ready = 1'b1;
    do_reset();
    n_vec++; if (imem_req_addr !== 32'h0) begin n_bad++; $display("FAIL stream_addr0: got %h want 00000000", imem_req_addr); end
    step();
    n_vec++; if (imem_req_addr !== 32'h4 || imem_req_valid !== 1'b1) begin n_bad++; $display("FAIL stream_addr4: got %h/%b want 00000004/1", imem_req_addr, imem_req_valid); end
    step();
    n_vec++; if (imem_req_addr !== 32'h8 || imem_req_valid !== 1'b1) begin n_bad++; $display("FAIL stream_addr8: got %h/%b want 00000008/1", imem_req_addr, imem_req_valid); end
    n_vec++; if (dec_valid !== 1'b1 || dec_pc !== 32'h0) begin n_bad++; $display("FAIL stream_dec0: got %b/%h want 1/00000000", dec_valid, dec_pc); end
    n_vec++; if (dec_inst !== 32'hA000_0000) begin n_bad++; $display("FAIL stream_inst0: got %h want a0000000", dec_inst); end
    step();
    n_vec++; if (dec_valid !== 1'b1 || dec_pc !== 32'h4) begin n_bad++; $display("FAIL stream_dec4: got %b/%h want 1/00000004", dec_valid, dec_pc); end
    n_vec++; if (dec_inst !== 32'hA000_0004) begin n_bad++; $display("FAIL stream_inst4: got %h want a0000004", dec_inst); end
    step();
    n_vec++; if (dec_valid !== 1'b1 || dec_pc !== 32'h8) begin n_bad++; $display("FAIL stream_dec8: got %b/%h want 1/00000008", dec_valid, dec_pc); end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_pc;
    lat = 1;
    dec_ready = 1'b0;
    do_reset();
    step();
    n_vec++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h4) begin n_bad++; $display("FAIL bp_second_req: got %b/%h want 1/00000004", imem_req_valid, imem_req_addr); end
    step();
    n_vec++; if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL bp_req_stop: got %b want 0", imem_req_valid); end
    for (int i = 0; i < 3; i++) begin
      step();
      n_vec++; if (dec_valid !== 1'b1 || dec_pc !== 32'h0 || imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL bp_hold%0d: got v=%b pc=%h req=%b want 1/00000000/0", i, dec_valid, dec_pc, imem_req_valid); end
    end
    dec_ready = 1'b1;
    #1;
    n_vec++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8) begin n_bad++; $display("FAIL bp_resume_req: got %b/%h want 1/00000008", imem_req_valid, imem_req_addr); end
    exp_pc = 32'h4;
    for (int i = 0; i < 3; i++) begin
      step();
      n_vec++; if (dec_valid !== 1'b1 || dec_pc !== exp_pc) begin n_bad++; $display("FAIL bp_order%0d: got %b/%h want 1/%h", i, dec_valid, dec_pc, exp_pc); end
      exp_pc = exp_pc + 32'h4;
    end
  endtask

  task automatic test_redirect_inflight();
    logic seen;
    lat = 3;
    dec_ready = 1'b1;
    do_reset();
    step();
    step();
    n_vec++; if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL rdi_outst_cap: got %b want 0", imem_req_valid); end
    redirect = 1'b1;
    redirect_pc = 32'h100;
    step();
    redirect = 1'b0;
    #1;
    n_vec++; if (dec_valid !== 1'b0) begin n_bad++; $display("FAIL rdi_no_stale_a: got %b want 0", dec_valid); end
    step();
    n_vec++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin n_bad++; $display("FAIL rdi_new_req: got %b/%h want 1/00000100", imem_req_valid, imem_req_addr); end
    n_vec++; if (dec_valid !== 1'b0) begin n_bad++; $display("FAIL rdi_no_stale_b: got %b want 0", dec_valid); end
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      step();
      if (dec_valid === 1'b1) seen = 1'b1;
    end
    n_vec++;
    if (!seen) begin n_bad++; $display("FAIL rdi_timeout: got no dec_valid want dec_valid within 12 clks"); end
    else if (dec_pc !== 32'h100 || dec_inst !== 32'hA000_0100) begin n_bad++; $display("FAIL rdi_first: got %h/%h want 00000100/a0000100", dec_pc, dec_inst); end
  endtask

  task automatic test_redirect_collide();
    logic seen;
    lat = 1;
    dec_ready = 1'b1;
    do_reset();
    step();
    step();
    n_vec++; if (dec_valid !== 1'b1 || dec_pc !== 32'h0) begin n_bad++; $display("FAIL rdc_setup: got %b/%h want 1/00000000", dec_valid, dec_pc); end
    redirect = 1'b1;
    redirect_pc = 32'h200;
    #1;
    n_vec++; if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL rdc_req_block: got %b want 0", imem_req_valid); end
    step();
    redirect = 1'b0;
    #1;
    n_vec++; if (dec_valid !== 1'b0 || dec_inst !== 32'h0000_0013) begin n_bad++; $display("FAIL rdc_flushed: got %b/%h want 0/00000013", dec_valid, dec_inst); end
    n_vec++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h200) begin n_bad++; $display("FAIL rdc_new_req: got %b/%h want 1/00000200", imem_req_valid, imem_req_addr); end
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      step();
      if (dec_valid === 1'b1) seen = 1'b1;
    end
    n_vec++;
    if (!seen) begin n_bad++; $display("FAIL rdc_timeout: got no dec_valid want dec_valid within 10 clks"); end
    else if (dec_pc !== 32'h200 || dec_inst !== 32'hA000_0200) begin n_bad++; $display("FAIL rdc_first: got %h/%h want 00000200/a0000200", dec_pc, dec_inst); end
  endtask

  task automatic test_reset_midflight();
    logic seen;
    lat = 3;
    dec_ready = 1'b1;
    do_reset();
    step();
    step();
    rst = 1'b1;
    step();
    n_vec++; if (imem_req_valid !== 1'b0 || dec_valid !== 1'b0) begin n_bad++; $display("FAIL rmf_outputs: got req=%b dv=%b want 0/0", imem_req_valid, dec_valid); end
    n_vec++; if (dec_inst !== 32'h0000_0013 || dec_pc !== 32'h0) begin n_bad++; $display("FAIL rmf_dec: got %h/%h want 00000013/00000000", dec_inst, dec_pc); end
    rst = 1'b0;
    step();
    n_vec++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin n_bad++; $display("FAIL rmf_first_req: got %b/%h want 1/00000000", imem_req_valid, imem_req_addr); end
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      step();
      if (dec_valid === 1'b1) seen = 1'b1;
    end
    n_vec++;
    if (!seen) begin n_bad++; $display("FAIL rmf_timeout: got no dec_valid want dec_valid within 10 clks"); end
    else if (dec_pc !== 32'h0 || dec_inst !== 32'hA000_0000) begin n_bad++; $display("FAIL rmf_first: got %h/%h want 00000000/a0000000", dec_pc, dec_inst); end
  endtask

  task automatic test_wrap();
    logic seen;
    lat = 1;
    dec_ready = 1'b1;
    do_reset();
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect = 1'b0;
    #1;
    n_vec++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL wrap_top: got %b/%h want 1/fffffffc", imem_req_valid, imem_req_addr); end
    step();
    n_vec++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin n_bad++; $display("FAIL wrap_zero: got %b/%h want 1/00000000", imem_req_valid, imem_req_addr); end
    redirect = 1'b1;
    redirect_pc = 32'h103;
    step();
    redirect = 1'b0;
    #1;
    n_vec++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin n_bad++; $display("FAIL wrap_align: got %b/%h want 1/00000100", imem_req_valid, imem_req_addr); end
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      step();
      if (dec_valid === 1'b1) seen = 1'b1;
    end
    n_vec++;
    if (!seen) begin n_bad++; $display("FAIL wrap_timeout: got no dec_valid want dec_valid within 10 clks"); end
    else if (dec_pc !== 32'h100 || dec_inst !== 32'hA000_0100) begin n_bad++; $display("FAIL wrap_first: got %h/%h want 00000100/a0000100", dec_pc, dec_inst); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_inflight();
    test_redirect_collide();
    test_reset_midflight();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by 200000 want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
